// File: rtl/toggle_pkg.sv
// Shared types and constants for the toggle event decoder.
// Optional input synchronizer is selected with the TOGGLE_DECODER_SYNC_EN macro.
package toggle_pkg;

    // Default width of the pending-event counter.
    localparam int unsigned CW_DEFAULT = 4;

    // Edges from a tog_in change to a visible ev_pulse.
    localparam int unsigned LAT_NOSYNC = 2;
    localparam int unsigned LAT_SYNC   = 3;

    // What the pending-event counter does on the next edge.
    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_SAT
    } cnt_act_e;

endpackage

// File: rtl/toggle_sampler.sv
// Samples the remote toggle level and flags each flip relative to the last
// accepted level. With TOGGLE_DECODER_SYNC_EN defined, tog_in goes through a
// two-flop synchronizer first. Otherwise a single sample flop is used, which
// is only suitable for synchronous sources.
module toggle_sampler (
    input  logic clk,
    input  logic clr_n,
    input  logic tog_in,
    output logic detect,
    output logic lvl
);

    logic lvl_q;
    logic lvl_d;
    logic samp;

`ifdef TOGGLE_DECODER_SYNC_EN
    logic s1_q;
    logic s2_q;

    // Two-flop synchronizer. Both stages load tog_in during reset, so the
    // release never exposes a stale level.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s1_q <= tog_in;
            s2_q <= tog_in;
        end else begin
            s1_q <= tog_in;
            s2_q <= s1_q;
        end
    end

    assign samp = s2_q;
`else
    logic tog_r_q;

    // Single sample flop; it tracks tog_in during reset as well.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            tog_r_q <= tog_in;
        end else begin
            tog_r_q <= tog_in;
        end
    end

    assign samp = tog_r_q;
`endif

    // A flip is any difference between the sampled level and the accepted one.
    always_comb begin
        detect = samp ^ lvl_q;
        lvl_d  = detect ? samp : lvl_q;
    end

    // Accepted level resynchronises to tog_in on every reset cycle.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            lvl_q <= tog_in;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign lvl = lvl_q;

endmodule

// File: rtl/toggle_event_decoder.sv
// Turns each flip of a remote toggle level into a one-cycle pulse and a
// saturating count of pending events, drained by a valid/ready consumer.
// Define TOGGLE_DECODER_SYNC_EN to add a two-flop input synchronizer.
module toggle_event_decoder
    import toggle_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          tog_in,
    input  logic          ev_ready,
    input  logic          ovf_clr,
    output logic          ev_pulse,
    output logic          ev_valid,
    output logic [CW-1:0] pend_cnt,
    output logic          overflow,
    output logic          lvl
);

    localparam logic [CW-1:0] MAXC = '1;

    logic          detect;
    logic          inc;
    logic          dec;
    cnt_act_e      cnt_act;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          pulse_q;

    toggle_sampler u_sampler (
        .clk    (clk),
        .clr_n  (clr_n),
        .tog_in (tog_in),
        .detect (detect),
        .lvl    (lvl)
    );

    assign ev_valid = (cnt_q != '0);

    // Decide the counter action; a simultaneous accept cancels the new event,
    // even at saturation, so nothing is lost in that case.
    always_comb begin
        inc = detect;
        dec = ev_valid & ev_ready;
        unique case ({inc, dec})
            2'b10:   cnt_act = (cnt_q == MAXC) ? CNT_SAT : CNT_INC;
            2'b01:   cnt_act = CNT_DEC;
            default: cnt_act = CNT_HOLD;
        endcase
    end

    // Next counter value and sticky overflow; a saturating event beats a clear.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unique case (cnt_act)
            CNT_INC: cnt_d = cnt_q + 1'b1;
            CNT_DEC: cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (cnt_act == CNT_SAT) begin
            ovf_d = 1'b1;
        end
    end

    // Registered state; reset discards pending events and overflow.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            pulse_q <= detect;
        end
    end

    assign ev_pulse = pulse_q;
    assign pend_cnt = cnt_q;
    assign overflow = ovf_q;

endmodule
